// File: rtl/phoenix_input_pkg.sv
// Shared constants for the phoenix input stage: PS/2 scancodes, joystick bit map,
// key-state indices and the coin FSM state type.
package phoenix_input_pkg;

    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    localparam logic [7:0] SC_CTRL  = 8'h14;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_F1    = 8'h05;
    localparam logic [7:0] SC_F2    = 8'h06;
    localparam logic [7:0] SC_KEY1  = 8'h16;
    localparam logic [7:0] SC_KEY2  = 8'h1E;
    localparam logic [7:0] SC_KEY5  = 8'h2E;
    localparam logic [7:0] SC_KEY6  = 8'h36;
    localparam logic [7:0] SC_R     = 8'h2D;
    localparam logic [7:0] SC_F     = 8'h2B;
    localparam logic [7:0] SC_D     = 8'h23;
    localparam logic [7:0] SC_G     = 8'h34;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_S     = 8'h1B;

    localparam int JOY_R       = 0;
    localparam int JOY_L       = 1;
    localparam int JOY_D       = 2;
    localparam int JOY_U       = 3;
    localparam int JOY_FIRE    = 4;
    localparam int JOY_BARRIER = 5;
    localparam int JOY_START1  = 6;
    localparam int JOY_START2  = 7;

    localparam int K_UP    = 0;
    localparam int K_DOWN  = 1;
    localparam int K_LEFT  = 2;
    localparam int K_RIGHT = 3;
    localparam int K_CTRL  = 4;
    localparam int K_SPACE = 5;
    localparam int K_F1    = 6;
    localparam int K_F2    = 7;
    localparam int K_KEY1  = 8;
    localparam int K_KEY2  = 9;
    localparam int K_KEY5  = 10;
    localparam int K_KEY6  = 11;
    localparam int K_R     = 12;
    localparam int K_F     = 13;
    localparam int K_D     = 14;
    localparam int K_G     = 15;
    localparam int K_A     = 16;
    localparam int K_S     = 17;
    localparam int NUM_KEYS = 18;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        HOLD  = 2'd2
    } coin_state_t;

    // One-hot key select; cursor keys and ctrl also answer to their extended codes.
    function automatic logic [NUM_KEYS-1:0] key_match(input logic ext, input logic [7:0] code);
        logic [NUM_KEYS-1:0] m;
        m          = '0;
        m[K_UP]    = (code == SC_UP);
        m[K_DOWN]  = (code == SC_DOWN);
        m[K_LEFT]  = (code == SC_LEFT);
        m[K_RIGHT] = (code == SC_RIGHT);
        m[K_CTRL]  = (code == SC_CTRL);
        m[K_SPACE] = !ext && (code == SC_SPACE);
        m[K_F1]    = !ext && (code == SC_F1);
        m[K_F2]    = !ext && (code == SC_F2);
        m[K_KEY1]  = !ext && (code == SC_KEY1);
        m[K_KEY2]  = !ext && (code == SC_KEY2);
        m[K_KEY5]  = !ext && (code == SC_KEY5);
        m[K_KEY6]  = !ext && (code == SC_KEY6);
        m[K_R]     = !ext && (code == SC_R);
        m[K_F]     = !ext && (code == SC_F);
        m[K_D]     = !ext && (code == SC_D);
        m[K_G]     = !ext && (code == SC_G);
        m[K_A]     = !ext && (code == SC_A);
        m[K_S]     = !ext && (code == SC_S);
        return m;
    endfunction

endpackage

// File: rtl/phoenix_input_ctrl_coin.sv
// Coin pulse generator: debounces the coin source, then emits one fixed-width
// pulse per accepted press.
module coin_pulse_gen
    import phoenix_input_pkg::*;
#(
    parameter int COIN_PULSE_CYCLES = 1100000,
    parameter int DEBOUNCE_CYCLES   = 11000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic src,
    output logic pulse
);

    localparam logic [15:0] DB_LAST    = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [23:0] PULSE_LAST = 24'(COIN_PULSE_CYCLES - 1);

    logic        db_reg, db_next;
    logic [15:0] db_cnt_reg, db_cnt_next;
    coin_state_t state_reg, state_next;
    logic [23:0] pulse_cnt_reg, pulse_cnt_next;
    logic        pulse_reg, pulse_next;

    // Counter runs only while src disagrees with the accepted level; any bounce clears it.
    always_comb begin
        db_next     = db_reg;
        db_cnt_next = '0;
        if (src != db_reg) begin
            if (db_cnt_reg == DB_LAST) begin
                db_next = src;
            end else begin
                db_cnt_next = db_cnt_reg + 16'd1;
            end
        end
    end

    // The pulse starts on the same edge the debounced level rises.
    always_comb begin
        state_next     = state_reg;
        pulse_cnt_next = pulse_cnt_reg;
        pulse_next     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (db_next && !db_reg) begin
                    state_next     = PULSE;
                    pulse_cnt_next = PULSE_LAST;
                    pulse_next     = 1'b1;
                end
            end
            PULSE: begin
                if (pulse_cnt_reg == '0) begin
                    state_next = HOLD;
                end else begin
                    pulse_cnt_next = pulse_cnt_reg - 24'd1;
                    pulse_next     = 1'b1;
                end
            end
            HOLD: begin
                if (!db_reg) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            db_reg        <= 1'b0;
            db_cnt_reg    <= '0;
            state_reg     <= IDLE;
            pulse_cnt_reg <= '0;
            pulse_reg     <= 1'b0;
        end else begin
            db_reg        <= db_next;
            db_cnt_reg    <= db_cnt_next;
            state_reg     <= state_next;
            pulse_cnt_reg <= pulse_cnt_next;
            pulse_reg     <= pulse_next;
        end
    end

    assign pulse = pulse_reg;

endmodule

// File: rtl/phoenix_input_ctrl.sv
// Phoenix input stage: PS/2 key decode merged with both joysticks, orientation-aware
// direction mapping and a registered button/coin interface to the core.
module phoenix_input_ctrl
    import phoenix_input_pkg::*;
#(
    parameter int COIN_PULSE_CYCLES = 1100000,
    parameter int DEBOUNCE_CYCLES   = 11000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [10:0] ps2_key,
    input  logic [15:0] joystick_0,
    input  logic [15:0] joystick_1,
    input  logic        rotate,
    output logic        btn_coin,
    output logic [1:0]  btn_player_start,
    output logic        btn_left,
    output logic        btn_right,
    output logic        btn_barrier,
    output logic        btn_fire
);

    logic                toggle_reg;
    logic                ps2_event;
    logic [NUM_KEYS-1:0] key_hit;
    logic [NUM_KEYS-1:0] key_reg;
    logic [7:0]          joy;
    logic                unused_joy_bits;
    logic                left_next, right_next, fire_next, barrier_next;
    logic [1:0]          start_next;
    logic                coin_src_next, coin_src_reg;

    assign ps2_event       = (ps2_key[10] != toggle_reg);
    assign key_hit         = key_match(ps2_key[8], ps2_key[7:0]);
    assign joy             = joystick_0[7:0] | joystick_1[7:0];
    assign unused_joy_bits = ^{joystick_0[15:8], joystick_1[15:8]};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            toggle_reg <= 1'b0;
        end else begin
            toggle_reg <= ps2_key[10];
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    key_reg[gi] <= 1'b0;
                end else if (ps2_event && key_hit[gi]) begin
                    key_reg[gi] <= ps2_key[9];
                end
            end
        end
    endgenerate

    // Rotated cabinets steer with up/down instead of left/right.
    assign left_next  = rotate ? (key_reg[K_DOWN] | key_reg[K_F] | joy[JOY_D])
                               : (key_reg[K_LEFT] | key_reg[K_D] | joy[JOY_L]);
    assign right_next = rotate ? (key_reg[K_UP] | key_reg[K_R] | joy[JOY_U])
                               : (key_reg[K_RIGHT] | key_reg[K_G] | joy[JOY_R]);
    assign fire_next     = key_reg[K_SPACE] | key_reg[K_A] | joy[JOY_FIRE];
    assign barrier_next  = key_reg[K_CTRL] | key_reg[K_S] | joy[JOY_BARRIER];
    assign start_next[0] = key_reg[K_F1] | key_reg[K_KEY1] | joy[JOY_START1];
    assign start_next[1] = key_reg[K_F2] | key_reg[K_KEY2] | joy[JOY_START2];
    assign coin_src_next = (|start_next) | key_reg[K_KEY5] | key_reg[K_KEY6];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            btn_player_start <= '0;
            btn_left         <= 1'b0;
            btn_right        <= 1'b0;
            btn_barrier      <= 1'b0;
            btn_fire         <= 1'b0;
            coin_src_reg     <= 1'b0;
        end else begin
            btn_player_start <= start_next;
            btn_left         <= left_next;
            btn_right        <= right_next;
            btn_barrier      <= barrier_next;
            btn_fire         <= fire_next;
            coin_src_reg     <= coin_src_next;
        end
    end

    coin_pulse_gen #(
        .COIN_PULSE_CYCLES(COIN_PULSE_CYCLES),
        .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES)
    ) u_coin (
        .clk    (clk),
        .reset_n(reset_n),
        .src    (coin_src_reg),
        .pulse  (btn_coin)
    );

endmodule

// File: tb/tb_phoenix_input_ctrl.sv
// Bench for phoenix_input_ctrl: directed scenarios plus a randomized run against a
// per-key behavioural model of the button mapping.
module tb_phoenix_input_ctrl;

    localparam int CP = 8;
    localparam int DB = 4;

    logic        clk;
    logic        reset_n;
    logic [10:0] ps2_key;
    logic [15:0] joystick_0;
    logic [15:0] joystick_1;
    logic        rotate;
    logic        btn_coin;
    logic [1:0]  btn_player_start;
    logic        btn_left;
    logic        btn_right;
    logic        btn_barrier;
    logic        btn_fire;

    int checks = 0;
    int errors = 0;
    logic tog = 1'b0;

    phoenix_input_ctrl #(
        .COIN_PULSE_CYCLES(CP),
        .DEBOUNCE_CYCLES  (DB)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .ps2_key         (ps2_key),
        .joystick_0      (joystick_0),
        .joystick_1      (joystick_1),
        .rotate          (rotate),
        .btn_coin        (btn_coin),
        .btn_player_start(btn_player_start),
        .btn_left        (btn_left),
        .btn_right       (btn_right),
        .btn_barrier     (btn_barrier),
        .btn_fire        (btn_fire)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ps2_send(input logic pressed, input logic [8:0] code);
        tog     = ~tog;
        ps2_key = {tog, pressed, code};
    endtask

    task automatic apply_reset();
        reset_n    = 1'b0;
        ps2_key    = '0;
        tog        = 1'b0;
        joystick_0 = '0;
        joystick_1 = '0;
        rotate     = 1'b0;
        step();
        step();
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_reset();
        reset_n    = 1'b0;
        joystick_0 = 16'h00FF;
        joystick_1 = 16'h00FF;
        rotate     = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if ({btn_coin, btn_player_start, btn_left, btn_right, btn_barrier, btn_fire} !== 6'b0) begin
                errors++;
                $display("FAIL reset_outputs: got %b expected 000000",
                         {btn_coin, btn_player_start, btn_left, btn_right, btn_barrier, btn_fire});
            end
        end
        $display("reset: outputs held low for 3 cycles");
        apply_reset();
    endtask

    task automatic test_start_coin();
        int pulses = 0;
        logic prev = 1'b0;
        apply_reset();
        ps2_send(1'b1, 9'h016);
        for (int k = 1; k <= 40; k++) begin
            logic exp_start, exp_coin;
            step();
            exp_start = (k >= 2 && k <= 21);
            exp_coin  = (k >= 2 + DB && k <= 1 + DB + CP);
            checks++;
            if (btn_player_start[0] !== exp_start) begin
                errors++;
                $display("FAIL key1_start cycle %0d: got %b expected %b", k, btn_player_start[0], exp_start);
            end
            checks++;
            if (btn_coin !== exp_coin) begin
                errors++;
                $display("FAIL key1_coin cycle %0d: got %b expected %b", k, btn_coin, exp_coin);
            end
            if (btn_coin && !prev) pulses++;
            prev = btn_coin;
            if (k == 20) ps2_send(1'b0, 9'h016);
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL key1_pulse_count: got %0d expected 1", pulses);
        end
        $display("start_coin: key1 press/release, %0d coin pulse(s)", pulses);
    endtask

    task automatic test_joy_rotate();
        apply_reset();
        joystick_0 = 16'h0002;
        step();
        checks++;
        if (btn_left !== 1'b1) begin
            errors++;
            $display("FAIL joy_left_rot0: got %b expected 1", btn_left);
        end
        rotate = 1'b1;
        step();
        checks++;
        if (btn_left !== 1'b0) begin
            errors++;
            $display("FAIL joy_left_rot1: got %b expected 0", btn_left);
        end
        joystick_1 = 16'h0004;
        step();
        checks++;
        if (btn_left !== 1'b1 || btn_right !== 1'b0) begin
            errors++;
            $display("FAIL joy1_down_rot1: got left=%b right=%b expected left=1 right=0", btn_left, btn_right);
        end
        $display("joy_rotate: left mapping across orientation checked");
    endtask

    task automatic test_extended();
        apply_reset();
        rotate = 1'b1;
        ps2_send(1'b1, 9'h175);
        step();
        checks++;
        if (btn_right !== 1'b0) begin
            errors++;
            $display("FAIL ext_up_latency: got %b expected 0", btn_right);
        end
        step();
        checks++;
        if (btn_right !== 1'b1) begin
            errors++;
            $display("FAIL ext_up_right: got %b expected 1", btn_right);
        end
        ps2_send(1'b1, 9'h129);
        for (int k = 1; k <= 4; k++) begin
            step();
            checks++;
            if (btn_fire !== 1'b0) begin
                errors++;
                $display("FAIL ext_fire_ignored cycle %0d: got %b expected 0", k, btn_fire);
            end
        end
        $display("extended: 0x175 drives right, 0x129 ignored");
    endtask

    task automatic test_bounce();
        int pulses = 0;
        logic prev = 1'b0;
        apply_reset();
        for (int b = 0; b < 4; b++) begin
            joystick_0 = (b % 2 == 0) ? 16'h0040 : 16'h0000;
            step();
            checks++;
            if (btn_coin !== 1'b0) begin
                errors++;
                $display("FAIL bounce_no_coin step %0d: got %b expected 0", b, btn_coin);
            end
        end
        joystick_0 = 16'h0040;
        // registered coin source rises at k=1; pulse begins DB edges later
        for (int k = 1; k <= 30; k++) begin
            logic exp_coin;
            step();
            exp_coin = (k >= 1 + DB && k <= DB + CP);
            checks++;
            if (btn_coin !== exp_coin) begin
                errors++;
                $display("FAIL bounce_coin cycle %0d: got %b expected %b", k, btn_coin, exp_coin);
            end
            if (btn_coin && !prev) pulses++;
            prev = btn_coin;
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL bounce_pulse_count: got %0d expected 1", pulses);
        end
        joystick_0 = '0;
        $display("bounce: %0d coin pulse(s) after bouncing start1", pulses);
    endtask

    task automatic test_reset_mid_pulse();
        apply_reset();
        // an unlisted code first, so the key1 press leaves the toggle at 0 (the reset value)
        ps2_send(1'b1, 9'h0AA);
        step();
        step();
        step();
        ps2_send(1'b1, 9'h016);
        for (int k = 1; k <= 8; k++) begin
            step();
            checks++;
            if (btn_coin !== (k >= 2 + DB)) begin
                errors++;
                $display("FAIL midpulse_pre cycle %0d: got %b expected %b", k, btn_coin, (k >= 2 + DB));
            end
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (btn_coin !== 1'b0) begin
            errors++;
            $display("FAIL midpulse_reset_drop: got %b expected 0", btn_coin);
        end
        step();
        step();
        reset_n = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            checks++;
            if (btn_coin !== 1'b0) begin
                errors++;
                $display("FAIL midpulse_no_repulse cycle %0d: got %b expected 0", k, btn_coin);
            end
        end
        ps2_send(1'b0, 9'h016);
        for (int k = 1; k <= 10; k++) step();
        ps2_send(1'b1, 9'h016);
        for (int k = 1; k <= 14; k++) begin
            logic exp_coin;
            step();
            exp_coin = (k >= 2 + DB && k <= 1 + DB + CP);
            checks++;
            if (btn_coin !== exp_coin) begin
                errors++;
                $display("FAIL midpulse_repress cycle %0d: got %b expected %b", k, btn_coin, exp_coin);
            end
        end
        $display("reset_mid_pulse: pulse dropped, new pulse only after re-press");
    endtask

    task automatic test_simultaneous();
        apply_reset();
        ps2_send(1'b1, 9'h029);
        step();
        step();
        checks++;
        if (btn_fire !== 1'b1) begin
            errors++;
            $display("FAIL space_fire: got %b expected 1", btn_fire);
        end
        joystick_0 = 16'h0010;
        ps2_send(1'b0, 9'h029);
        for (int k = 1; k <= 6; k++) begin
            step();
            checks++;
            if (btn_fire !== 1'b1) begin
                errors++;
                $display("FAIL fire_overlap cycle %0d: got %b expected 1", k, btn_fire);
            end
        end
        joystick_0 = '0;
        step();
        checks++;
        if (btn_fire !== 1'b0) begin
            errors++;
            $display("FAIL fire_release: got %b expected 0", btn_fire);
        end
        $display("simultaneous: fire held across key release/joystick press");
    endtask

    // Behavioural model: key states by name, updated from the scancode table.
    bit m_up, m_down, m_left, m_right, m_ctrl, m_space, m_f1, m_f2, m_key1, m_key2;
    bit m_key5, m_key6, m_r, m_f, m_d, m_g, m_a, m_s;

    task automatic model_key(input bit pressed, input logic [8:0] c);
        case (c[7:0])
            8'h75: m_up    = pressed;
            8'h72: m_down  = pressed;
            8'h6B: m_left  = pressed;
            8'h74: m_right = pressed;
            8'h14: m_ctrl  = pressed;
            8'h29: if (!c[8]) m_space = pressed;
            8'h05: if (!c[8]) m_f1    = pressed;
            8'h06: if (!c[8]) m_f2    = pressed;
            8'h16: if (!c[8]) m_key1  = pressed;
            8'h1E: if (!c[8]) m_key2  = pressed;
            8'h2E: if (!c[8]) m_key5  = pressed;
            8'h36: if (!c[8]) m_key6  = pressed;
            8'h2D: if (!c[8]) m_r     = pressed;
            8'h2B: if (!c[8]) m_f     = pressed;
            8'h23: if (!c[8]) m_d     = pressed;
            8'h34: if (!c[8]) m_g     = pressed;
            8'h1C: if (!c[8]) m_a     = pressed;
            8'h1B: if (!c[8]) m_s     = pressed;
            default: ;
        endcase
    endtask

    task automatic test_random();
        logic [8:0] code_tbl [28] = '{9'h075, 9'h175, 9'h072, 9'h172, 9'h06B, 9'h16B, 9'h074,
                                      9'h174, 9'h014, 9'h114, 9'h029, 9'h129, 9'h005, 9'h006,
                                      9'h016, 9'h01E, 9'h02E, 9'h036, 9'h02D, 9'h02B, 9'h023,
                                      9'h034, 9'h01C, 9'h01B, 9'h116, 9'h11C, 9'h0AA, 9'h12D};
        int bad = 0;
        apply_reset();
        {m_up, m_down, m_left, m_right, m_ctrl, m_space, m_f1, m_f2, m_key1} = '0;
        {m_key2, m_key5, m_key6, m_r, m_f, m_d, m_g, m_a, m_s} = '0;
        for (int n = 0; n < 400; n++) begin
            logic [7:0] j;
            logic [5:0] exp_v, got_v;
            bit ev, pr;
            logic [8:0] c;
            joystick_0 = 16'($urandom) & 16'hFF00 | 16'(($urandom % 4 == 0) ? $urandom_range(0, 255) : 0);
            joystick_1 = (n % 7 == 0) ? 16'($urandom_range(0, 255)) : 16'h0000;
            if ($urandom % 10 == 0) rotate = ~rotate;
            ev = ($urandom % 3 == 0);
            pr = $urandom_range(0, 1);
            c  = code_tbl[$urandom_range(0, 27)];
            if (ev) ps2_send(pr, c);
            j = joystick_0[7:0] | joystick_1[7:0];
            exp_v[5] = m_f2 | m_key2 | j[7];
            exp_v[4] = m_f1 | m_key1 | j[6];
            exp_v[3] = rotate ? (m_down | m_f | j[2]) : (m_left | m_d | j[1]);
            exp_v[2] = rotate ? (m_up | m_r | j[3]) : (m_right | m_g | j[0]);
            exp_v[1] = m_ctrl | m_s | j[5];
            exp_v[0] = m_space | m_a | j[4];
            if (ev) model_key(pr, c);
            step();
            got_v = {btn_player_start[1], btn_player_start[0], btn_left, btn_right, btn_barrier, btn_fire};
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                bad++;
                $display("FAIL random_map cycle %0d: got %b expected %b (start2,start1,left,right,barrier,fire)",
                         n, got_v, exp_v);
            end
        end
        $display("random: 400 cycles of mixed PS/2 and joystick stimulus, %0d mismatching cycles", bad);
    endtask

    initial begin
        ps2_key    = '0;
        joystick_0 = '0;
        joystick_1 = '0;
        rotate     = 1'b0;
        reset_n    = 1'b0;
        test_reset();
        test_start_coin();
        test_joy_rotate();
        test_extended();
        test_bounce();
        test_reset_mid_pulse();
        test_simultaneous();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
